// File: rtl/design_sel_ctrl_if.sv
// Serial configuration input and design-select outputs of design_sel_ctrl, bundled as one port.
interface design_sel_ctrl_if #(
    parameter int SEL_W = 6
);
    logic             cfg_en;
    logic             cfg_data;
    logic [SEL_W-1:0] des_sel;
    logic             hold_if_not_sel;
    logic             des_reset_req;
    logic             cfg_busy;
    logic             cfg_err;

    modport master (
        output cfg_en, cfg_data,
        input  des_sel, hold_if_not_sel, des_reset_req, cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_en, cfg_data,
        output des_sel, hold_if_not_sel, des_reset_req, cfg_busy, cfg_err
    );
endinterface

// File: rtl/design_sel_ctrl.sv
// Design-multiplexer select controller: receives a serial select frame, validates it, switches
// des_sel and holds the newly selected design in reset for RST_CYCLES cycles.
module design_sel_ctrl #(
    parameter int SEL_W       = 6,
    parameter int RST_CYCLES  = 8,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clock,
    input  logic             reset,
    design_sel_ctrl_if.slave bus
);
    localparam int FLEN    = SEL_W + 3;
    localparam int CNT_MAX = (RST_CYCLES > FLEN + 1) ? RST_CYCLES : FLEN + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        SWITCH
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [FLEN-1:0]  shreg, shreg_next;
    logic [SEL_W-1:0] sel_q, sel_next;
    logic             hold_q, hold_next;
    logic             err_q, err_next;
    logic             en_prev;
    logic             accept;

    // Frame is {start, sel, hold, parity}; parity makes the XOR of everything after start odd.
    assign accept = (cnt == CNT_W'(FLEN)) && shreg[FLEN-1] && (^shreg[FLEN-2:0]);

    // en_prev resets high so a cfg_en already high at reset release cannot start a frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SWITCH;
            cnt     <= '0;
            shreg   <= '0;
            sel_q   <= SEL_W'(DEFAULT_SEL);
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
            en_prev <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            shreg   <= shreg_next;
            sel_q   <= sel_next;
            hold_q  <= hold_next;
            err_q   <= err_next;
            en_prev <= bus.cfg_en;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shreg_next = shreg;
        sel_next   = sel_q;
        hold_next  = hold_q;
        err_next   = err_q;
        case (state)
            IDLE: begin
                if (bus.cfg_en && !en_prev) begin
                    shreg_next = {shreg[FLEN-2:0], bus.cfg_data};
                    cnt_next   = CNT_W'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.cfg_en) begin
                    shreg_next = {shreg[FLEN-2:0], bus.cfg_data};
                    // Saturating at FLEN+1 keeps an overlong frame distinguishable from a good one.
                    if (cnt != CNT_W'(FLEN + 1)) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    sel_next   = shreg[FLEN-2:2];
                    hold_next  = shreg[1];
                    err_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = SWITCH;
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            SWITCH: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.des_sel         = sel_q;
    assign bus.hold_if_not_sel = hold_q;
    assign bus.cfg_err         = err_q;
    assign bus.des_reset_req   = (state == SWITCH);
    assign bus.cfg_busy        = (state != IDLE);
endmodule

// File: tb/tb_design_sel_ctrl.sv
// Scoreboard bench for design_sel_ctrl: each directed frame pushes per-cycle expected outputs,
// which are popped and compared one cycle at a time.
module tb_design_sel_ctrl;
    localparam int SEL_W      = 6;
    localparam int RST_CYCLES = 8;
    localparam int FLEN       = SEL_W + 3;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             hold;
        logic             req;
        logic             busy;
        logic             err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t             sb[$];
    logic [SEL_W-1:0] m_sel;
    logic             m_hold;
    logic             m_err;

    always #5 clock = ~clock;

    design_sel_ctrl_if #(.SEL_W(SEL_W)) bus ();

    design_sel_ctrl #(
        .SEL_W      (SEL_W),
        .RST_CYCLES (RST_CYCLES),
        .DEFAULT_SEL(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [SEL_W-1:0] sel, input logic hold, input logic req,
                        input logic busy, input logic err);
        exp_t e;
        e.sel  = sel;
        e.hold = hold;
        e.req  = req;
        e.busy = busy;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic push_switch();
        for (int i = 0; i < RST_CYCLES; i++) push(m_sel, m_hold, 1'b1, 1'b1, 1'b0);
        push(m_sel, m_hold, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp_v);
        end
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        e = sb.pop_front();
        cmp({tag, ".des_sel"},  {2'b00, bus.des_sel},          {2'b00, e.sel});
        cmp({tag, ".hold"},     {7'd0, bus.hold_if_not_sel},   {7'd0, e.hold});
        cmp({tag, ".rst_req"},  {7'd0, bus.des_reset_req},     {7'd0, e.req});
        cmp({tag, ".busy"},     {7'd0, bus.cfg_busy},          {7'd0, e.busy});
        cmp({tag, ".err"},      {7'd0, bus.cfg_err},           {7'd0, e.err});
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) begin
            checkOutput(tag);
            if (sb.size() > 0) tick();
        end
    endtask

    // Sends len bits (frame[len-1] first), then drops cfg_en; optionally re-raises it at once.
    task automatic applyStimulus(input logic [15:0] frame, input int len, input logic keep_en);
        logic ok;
        for (int i = len - 1; i >= 0; i--) begin
            bus.cfg_en   = 1'b1;
            bus.cfg_data = frame[i];
            tick();
        end
        bus.cfg_en   = 1'b0;
        bus.cfg_data = 1'b0;
        tick();
        if (keep_en) begin
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 1'b1;
        end
        ok = (len == FLEN) && frame[FLEN-1] && (^frame[FLEN-2:0]);
        push(m_sel, m_hold, 1'b0, 1'b1, m_err);
        if (ok) begin
            m_sel  = frame[FLEN-2:2];
            m_hold = frame[1];
            m_err  = 1'b0;
            push_switch();
        end else begin
            m_err = 1'b1;
            push(m_sel, m_hold, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.cfg_en   = 1'b0;
        bus.cfg_data = 1'b0;
        m_sel        = '0;
        m_hold       = 1'b0;
        m_err        = 1'b0;

        // Reset state and the post-release reset window
        tick();
        tick();
        push('0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("in_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        push_switch();
        drain("release");

        // Valid frame sel=11 hold=1
        applyStimulus(16'(9'b1_001011_1_1), 9, 1'b0);
        drain("frame_sel11");

        // Parity error
        applyStimulus(16'(9'b1_001011_1_0), 9, 1'b0);
        drain("bad_parity");

        // Short and long frames, then a valid frame clearing cfg_err
        applyStimulus(16'(8'b1_001011_1), 8, 1'b0);
        drain("short_frame");
        applyStimulus(16'(10'b1_001011_1_1_0), 10, 1'b0);
        drain("long_frame");
        applyStimulus(16'(9'b1_000000_0_1), 9, 1'b0);
        drain("frame_sel0");

        // cfg_en raised during CHECK/SWITCH and held high into IDLE must be ignored
        applyStimulus(16'(9'b1_001011_1_1), 9, 1'b1);
        for (int i = 0; i < 4; i++) push(m_sel, m_hold, 1'b0, 1'b0, 1'b0);
        drain("en_held");
        bus.cfg_en = 1'b0;
        tick();
        push(m_sel, m_hold, 1'b0, 1'b0, 1'b0);
        drain("en_low");
        applyStimulus(16'(9'b1_001011_0_0), 9, 1'b0);
        drain("after_rise");

        // Reset in the middle of a sel=40 frame
        for (int i = 8; i >= 4; i--) begin
            bus.cfg_en   = 1'b1;
            bus.cfg_data = 1'(9'b1_101000_0_1 >> i);
            tick();
        end
        reset = 1'b1;
        #1;
        m_sel  = '0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        push(m_sel, m_hold, 1'b1, 1'b1, 1'b0);
        checkOutput("mid_reset");
        bus.cfg_en   = 1'b0;
        bus.cfg_data = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        push_switch();
        drain("mid_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
